// File: rtl/button_press_decoder.sv
// Turns a debounced button level into one-cycle press/short/long/repeat/release events.
// Auto-repeat is built only when BUTTON_REPEAT_EN is defined; otherwise repeat_pulse is tied 0.
//
// state   | meaning
// IDLE    | button not accepted as pressed; waiting for a rising edge
// PRESSED | accepted press, hold shorter than LONG_TICKS so far
// HELD    | long press reached; waiting for release (and repeating if enabled)
module button_press_decoder #(
    parameter int LONG_TICKS   = 50,
    parameter int REPEAT_TICKS = 10,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_db,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic release_pulse,
    output logic held
);

    // Compare values must fit in cnt so it can never wrap.
    if (LONG_TICKS < 2 || LONG_TICKS >= (1 << CNT_W)) begin : g_bad_long
        $error("button_press_decoder: LONG_TICKS out of range");
    end
    if (REPEAT_TICKS < 2 || REPEAT_TICKS >= (1 << CNT_W)) begin : g_bad_repeat
        $error("button_press_decoder: REPEAT_TICKS out of range");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             btn_q;
    logic             rise;
    logic             fall;

    assign rise = btn_db & ~btn_q;
    assign fall = ~btn_db & btn_q;

`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
    logic repeat_q;
    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            // Loading the live level suppresses a phantom press for a button held through reset.
            btn_q         <= btn_db;
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            release_pulse <= 1'b0;
            held          <= 1'b0;
`ifdef BUTTON_REPEAT_EN
            repeat_q      <= 1'b0;
`endif
        end else begin
            btn_q         <= btn_db;
            press_pulse   <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            release_pulse <= 1'b0;
`ifdef BUTTON_REPEAT_EN
            repeat_q      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    held <= 1'b0;
                    if (rise) begin
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                        cnt         <= '0;
                        state       <= PRESSED;
                    end
                end
                PRESSED: begin
                    cnt <= cnt + CNT_W'(1);
                    // A release on the threshold cycle still counts as short.
                    if (fall) begin
                        short_pulse   <= 1'b1;
                        release_pulse <= 1'b1;
                        state         <= IDLE;
                    end else if (cnt == LONG_LAST) begin
                        long_pulse <= 1'b1;
                        cnt        <= '0;
                        state      <= HELD;
                    end
                end
                HELD: begin
`ifdef BUTTON_REPEAT_EN
                    cnt <= cnt + CNT_W'(1);
                    if (fall) begin
                        release_pulse <= 1'b1;
                        state         <= IDLE;
                    end else if (cnt == REPEAT_LAST) begin
                        repeat_q <= 1'b1;
                        cnt      <= '0;
                    end
`else
                    if (fall) begin
                        release_pulse <= 1'b1;
                        state         <= IDLE;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_press_decoder.sv
// Bench for button_press_decoder: directed segment table plus random level runs checked
// every cycle against a hold-length based event model.
module tb_button_press_decoder;

    localparam int LONG   = 50;
    localparam int REPEAT = 10;
`ifdef BUTTON_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic btn_db;
    logic press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held;

    int n_total = 0;
    int n_bad   = 0;

    button_press_decoder #(
        .LONG_TICKS  (LONG),
        .REPEAT_TICKS(REPEAT),
        .CNT_W       (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_db       (btn_db),
        .press_pulse  (press_pulse),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .release_pulse(release_pulse),
        .held         (held)
    );

    always #5 clk = ~clk;

    // Reference model: an accepted press is a run of high samples starting at a rise;
    // events follow from the run length (len = high samples so far, press edge = 1).
    bit       m_valid = 1'b0;
    bit       m_acc   = 1'b0;
    bit       m_prev  = 1'b0;
    int       m_len   = 0;
    bit [5:0] exp_v   = '0;  // {press, short, long, repeat, release, held}

    always @(posedge clk) begin
        bit e_press, e_short, e_long, e_rep, e_rel;
        e_press = 0; e_short = 0; e_long = 0; e_rep = 0; e_rel = 0;
        if (rst) begin
            m_valid = 1'b1;
            m_acc   = 1'b0;
            m_len   = 0;
        end else if (!m_acc) begin
            if (btn_db && !m_prev) begin
                e_press = 1;
                m_acc   = 1'b1;
                m_len   = 1;
            end
        end else if (btn_db) begin
            m_len = m_len + 1;
            if (m_len == LONG + 1)
                e_long = 1;
            else if (REP_EN && m_len > LONG + 1 && ((m_len - LONG - 1) % REPEAT) == 0)
                e_rep = 1;
        end else begin
            e_rel   = 1;
            e_short = (m_len <= LONG);
            m_acc   = 1'b0;
        end
        m_prev = btn_db;
        exp_v  = {e_press, e_short, e_long, e_rep, e_rel, (m_acc | e_rel) & !rst};
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_total++;
            if ({press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held} !== exp_v) begin
                n_bad++;
                $display("FAIL model_cycle t=%0t got={p,s,l,r,rel,h}=%b want=%b", $time,
                         {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held}, exp_v);
            end
        end
    end

    typedef struct {
        bit rst;
        bit btn;
        int cycles;
        int n_press;
        int n_short;
        int n_long;
        int n_rep;
        int n_rel;
        bit held_end;
    } seg_t;

    task automatic run_seg(input bit r, input bit b, input int n,
                           output int cp, output int cs, output int cl,
                           output int cr, output int crl, output bit h);
        cp = 0; cs = 0; cl = 0; cr = 0; crl = 0; h = 0;
        for (int i = 0; i < n; i++) begin
            rst    = r;
            btn_db = b;
            @(posedge clk);
            @(negedge clk);
            cp  += int'(press_pulse);
            cs  += int'(short_pulse);
            cl  += int'(long_pulse);
            cr  += int'(repeat_pulse);
            crl += int'(release_pulse);
            h    = held;
        end
    endtask

    task automatic chk(input string name, input int idx, input int got, input int want);
        n_total++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s seg=%0d got=%0d want=%0d", name, idx, got, want);
        end
    endtask

    seg_t tbl[14];

    initial begin
        int  cp, cs, cl, cr, crl;
        bit  h;
        int  rep85, rep60;
        rep85 = REP_EN ? 3 : 0;
        rep60 = REP_EN ? 1 : 0;

        rst    = 1'b1;
        btn_db = 1'b1;

        tbl[0]  = '{1'b1, 1'b1,   2, 0, 0, 0, 0,     0, 1'b0};  // reset with button down
        tbl[1]  = '{1'b0, 1'b1, 100, 0, 0, 0, 0,     0, 1'b0};  // held through reset: ignored
        tbl[2]  = '{1'b0, 1'b0,   3, 0, 0, 0, 0,     0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1,  20, 1, 0, 0, 0,     0, 1'b1};  // short press
        tbl[4]  = '{1'b0, 1'b0,   3, 0, 1, 0, 0,     1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1,  85, 1, 0, 1, rep85, 0, 1'b1};  // long press + repeats
        tbl[6]  = '{1'b0, 1'b0,   3, 0, 0, 0, 0,     1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1,  50, 1, 0, 0, 0,     0, 1'b1};  // fall lands on threshold
        tbl[8]  = '{1'b0, 1'b0,   1, 0, 1, 0, 0,     1, 1'b1};
        tbl[9]  = '{1'b0, 1'b1,   5, 1, 0, 0, 0,     0, 1'b1};  // re-press right after release
        tbl[10] = '{1'b0, 1'b1,  60, 0, 0, 1, rep60, 0, 1'b1};
        tbl[11] = '{1'b1, 1'b1,   1, 0, 0, 0, 0,     0, 1'b0};  // reset while HELD
        tbl[12] = '{1'b0, 1'b1,  10, 0, 0, 0, 0,     0, 1'b0};
        tbl[13] = '{1'b0, 1'b0,   2, 0, 0, 0, 0,     0, 1'b0};  // no release after reset

        for (int i = 0; i < 14; i++) begin
            run_seg(tbl[i].rst, tbl[i].btn, tbl[i].cycles, cp, cs, cl, cr, crl, h);
            chk("press_cnt",   i, cp,     tbl[i].n_press);
            chk("short_cnt",   i, cs,     tbl[i].n_short);
            chk("long_cnt",    i, cl,     tbl[i].n_long);
            chk("repeat_cnt",  i, cr,     tbl[i].n_rep);
            chk("release_cnt", i, crl,    tbl[i].n_rel);
            chk("held_end",    i, int'(h), int'(tbl[i].held_end));
        end

        // Random runs; lengths biased around the long threshold, occasional resets.
        for (int s = 0; s < 80; s++) begin
            bit r, b;
            int n;
            r = ($urandom_range(0, 24) == 0);
            b = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       n = $urandom_range(1, 5);
                1:       n = $urandom_range(LONG - 3, LONG + 3);
                default: n = $urandom_range(1, 110);
            endcase
            if (r) n = $urandom_range(1, 3);
            run_seg(r, b, n, cp, cs, cl, cr, crl, h);
        end

        rst = 1'b0;
        btn_db = 1'b0;
        @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
